edge_ref_source: RTL and testbench

Reference source and lock supervisor for the edge of the cartesian ADPLL network. It generates the reference clock and its divide-by-8 that drive the `ref_left_i` / `ref_above_i` inputs of boundary nodes. It consumes the signed phase error those nodes return and runs an acquire/lock/loss state machine, which reports network lock to the top level. Everything runs in the single FPGA clock domain.

---
 rtl/edge_ref_source.sv | 178 +++++++++++++++++
 tb/tb_edge_ref_source.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_ref_source.sv
// Edge reference source for the cartesian ADPLL network.
// An NCO produces the reference clock and its divide-by-8, which boundary nodes
// lock to. A supervisor samples the phase error those nodes return and tracks
// the acquire / lock / loss state of the network.
module edge_ref_source #(
  parameter int                    ACCUM_WIDTH = 12,
  parameter int                    PDET_WIDTH  = 8,
  parameter logic [PDET_WIDTH-1:0] LOCK_THRESH = 8'd2,
  parameter int                    LOCK_COUNT  = 16,
  parameter int                    LOSS_COUNT  = 4,
  parameter int                    CNT_WIDTH   = 5
) (
  input  logic                   fpga_clk_i,
  input  logic                   reset_n_i,
  input  logic                   enable_i,
  input  logic [ACCUM_WIDTH-1:0] k_val_i,
  input  logic [PDET_WIDTH-1:0]  error_i,
  output logic                   ref_clk_o,
  output logic                   ref_div8_o,
  output logic                   locked_o,
  output logic                   lock_lost_o,
  output logic [PDET_WIDTH-2:0]  err_peak_o,
  output logic [1:0]             state_o
);

  localparam int MSB = ACCUM_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10
  } state_t;

  // Magnitude of a signed error; the most negative code folds onto the largest
  // positive magnitude so the result always fits in PDET_WIDTH-1 bits.
  function automatic logic [PDET_WIDTH-2:0] sat_abs(input logic [PDET_WIDTH-1:0] e);
    logic [PDET_WIDTH-1:0] mag;
    if (e[PDET_WIDTH-1])
      mag = ~e + PDET_WIDTH'(1);
    else
      mag = e;
    if (mag[PDET_WIDTH-1])
      return '1;
    else
      return mag[PDET_WIDTH-2:0];
  endfunction

  logic [ACCUM_WIDTH-1:0] acc_q;
  logic [ACCUM_WIDTH-1:0] acc_next;
  logic [ACCUM_WIDTH-1:0] k_val_q;
  logic [2:0]             div_cnt_q;
  logic                   acc_rise;
  logic                   div_rise;
  logic                   div_fall;
  logic [PDET_WIDTH-2:0]  err_abs_q;
  logic                   sample_vld_q;

  state_t                 state_q;
  logic                   locked_q;
  logic                   lock_lost_q;
  logic [PDET_WIDTH-2:0]  err_peak_q;
  logic [CNT_WIDTH-1:0]   lock_cnt_q;
  logic [CNT_WIDTH-1:0]   loss_cnt_q;
  logic [CNT_WIDTH-1:0]   lock_cnt_inc;
  logic [CNT_WIDTH-1:0]   loss_cnt_inc;
  logic                   in_thresh;

  // The divider and the k_val reload are keyed off the accumulator MSB rising on
  // the coming edge, so ref_div8 moves on the same edge as the ref_clk rise.
  assign acc_next = acc_q + k_val_q;
  assign acc_rise = ~acc_q[MSB] & acc_next[MSB];
  assign div_rise = acc_rise && (div_cnt_q == 3'd3);
  assign div_fall = acc_rise && (div_cnt_q == 3'd7);

  assign lock_cnt_inc = (lock_cnt_q == '1) ? lock_cnt_q : lock_cnt_q + CNT_WIDTH'(1);
  assign loss_cnt_inc = (loss_cnt_q == '1) ? loss_cnt_q : loss_cnt_q + CNT_WIDTH'(1);
  assign in_thresh    = ({1'b0, err_abs_q} <= LOCK_THRESH);

  // Oscillator, divider, frequency-word capture and error sampling.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_q        <= '0;
      k_val_q      <= '0;
      div_cnt_q    <= '0;
      err_abs_q    <= '0;
      sample_vld_q <= 1'b0;
    end else if (!enable_i) begin
      acc_q        <= '0;
      k_val_q      <= '0;
      div_cnt_q    <= '0;
      err_abs_q    <= '0;
      sample_vld_q <= 1'b0;
    end else begin
      acc_q        <= acc_next;
      sample_vld_q <= div_fall;
      if (state_q == ST_IDLE || div_rise)
        k_val_q <= k_val_i;
      if (acc_rise)
        div_cnt_q <= div_cnt_q + 3'd1;
      if (div_fall)
        err_abs_q <= sat_abs(error_i);
    end
  end

  // Lock supervisor: evaluates each captured sample one cycle after capture.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      err_peak_q  <= '0;
      lock_cnt_q  <= '0;
      loss_cnt_q  <= '0;
    end else begin
      lock_lost_q <= 1'b0;
      if (!enable_i) begin
        state_q    <= ST_IDLE;
        locked_q   <= 1'b0;
        lock_cnt_q <= '0;
        loss_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            if (sample_vld_q) begin
              if (in_thresh) begin
                if (lock_cnt_inc >= CNT_WIDTH'(LOCK_COUNT)) begin
                  state_q    <= ST_LOCKED;
                  locked_q   <= 1'b1;
                  lock_cnt_q <= '0;
                  loss_cnt_q <= '0;
                  err_peak_q <= '0;
                end else begin
                  lock_cnt_q <= lock_cnt_inc;
                end
              end else begin
                lock_cnt_q <= '0;
              end
            end
          end
          ST_LOCKED: begin
            if (sample_vld_q) begin
              if (err_abs_q > err_peak_q)
                err_peak_q <= err_abs_q;
              if (!in_thresh) begin
                if (loss_cnt_inc >= CNT_WIDTH'(LOSS_COUNT)) begin
                  state_q     <= ST_ACQUIRE;
                  locked_q    <= 1'b0;
                  lock_lost_q <= 1'b1;
                  loss_cnt_q  <= '0;
                  lock_cnt_q  <= '0;
                end else begin
                  loss_cnt_q <= loss_cnt_inc;
                end
              end else begin
                loss_cnt_q <= '0;
              end
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ref_clk_o   = acc_q[MSB];
  assign ref_div8_o  = div_cnt_q[2];
  assign locked_o    = locked_q;
  assign lock_lost_o = lock_lost_q;
  assign err_peak_o  = err_peak_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_edge_ref_source.sv
// Testbench for edge_ref_source. Stimulus pushes expected output snapshots
// (tagged with the cycle they apply to) into a scoreboard queue; a monitor on
// the falling clock edge pops and compares them, and separately matches every
// lock_lost_o pulse against a queue of expected pulse cycles.
module tb_edge_ref_source;

  localparam int M_CLK  = 1;
  localparam int M_DIV  = 2;
  localparam int M_LCK  = 4;
  localparam int M_LOST = 8;
  localparam int M_ST   = 16;
  localparam int M_PK   = 32;
  localparam int M_ALL  = 63;

  typedef struct {
    int         at;
    int         mask;
    logic       clk;
    logic       div;
    logic       lck;
    logic       lost;
    logic [1:0] st;
    logic [6:0] pk;
    string      name;
  } exp_t;

  logic        fpga_clk = 1'b0;
  logic        reset_n  = 1'b1;
  logic        enable   = 1'b0;
  logic [11:0] k_val    = '0;
  logic [7:0]  error_in = '0;
  logic        ref_clk;
  logic        ref_div8;
  logic        locked;
  logic        lock_lost;
  logic [6:0]  err_peak;
  logic [1:0]  state;

  int   cyc    = 0;
  int   t0     = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   pulse_q[$];

  edge_ref_source #(
    .ACCUM_WIDTH(12),
    .PDET_WIDTH (8),
    .LOCK_THRESH(8'd2),
    .LOCK_COUNT (16),
    .LOSS_COUNT (4),
    .CNT_WIDTH  (5)
  ) dut (
    .fpga_clk_i (fpga_clk),
    .reset_n_i  (reset_n),
    .enable_i   (enable),
    .k_val_i    (k_val),
    .error_i    (error_in),
    .ref_clk_o  (ref_clk),
    .ref_div8_o (ref_div8),
    .locked_o   (locked),
    .lock_lost_o(lock_lost),
    .err_peak_o (err_peak),
    .state_o    (state)
  );

  // Free-running clock and edge counter.
  always #5 fpga_clk = ~fpga_clk;
  always @(posedge fpga_clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic en, input logic [11:0] k, input logic [7:0] err);
    enable   = en;
    k_val    = k;
    error_in = err;
  endtask

  task automatic wait_until(input int n);
    while (cyc < t0 + n) @(negedge fpga_clk);
  endtask

  function void expect_at(int n, int mask, logic clk, logic div, logic lck, logic lost,
                          logic [1:0] st, logic [6:0] pk, string name);
    exp_t e;
    e.at = t0 + n; e.mask = mask; e.clk = clk; e.div = div; e.lck = lck;
    e.lost = lost; e.st = st; e.pk = pk; e.name = name;
    sb.push_back(e);
  endfunction

  task automatic checkOutput(input exp_t e);
    logic bad;
    bad = 1'b0;
    if ((e.mask & M_CLK)  != 0 && ref_clk   !== e.clk)  bad = 1'b1;
    if ((e.mask & M_DIV)  != 0 && ref_div8  !== e.div)  bad = 1'b1;
    if ((e.mask & M_LCK)  != 0 && locked    !== e.lck)  bad = 1'b1;
    if ((e.mask & M_LOST) != 0 && lock_lost !== e.lost) bad = 1'b1;
    if ((e.mask & M_ST)   != 0 && state     !== e.st)   bad = 1'b1;
    if ((e.mask & M_PK)   != 0 && err_peak  !== e.pk)   bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d mask=%0h got clk=%b div=%b lck=%b lost=%b st=%b pk=%0d want clk=%b div=%b lck=%b lost=%b st=%b pk=%0d",
               e.name, cyc, e.mask, ref_clk, ref_div8, locked, lock_lost, state, err_peak,
               e.clk, e.div, e.lck, e.lost, e.st, e.pk);
    end
  endtask

  // Monitor: compares scheduled snapshots and accounts for every lock_lost pulse.
  always @(negedge fpga_clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s missed snapshot: due at cyc %0d, now %0d", e.name, e.at, cyc);
      end else begin
        checkOutput(e);
      end
    end
    while (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL lock_lost_pulse missing: expected at cyc %0d, now %0d", pulse_q[0], cyc);
      void'(pulse_q.pop_front());
    end
    if (lock_lost === 1'b1) begin
      checks++;
      if (pulse_q.size() > 0 && pulse_q[0] == cyc) begin
        void'(pulse_q.pop_front());
      end else begin
        errors++;
        $display("[TB] FAIL lock_lost_pulse unexpected: got 1 at cyc %0d, want 0", cyc);
      end
    end
  end

  // Directed stimulus. All n values are edges counted from the enable edge (n=0)
  // with K=256: ref_clk rises on n=8+16r, samples land on n=120+128(j-1).
  initial begin
    #1 reset_n = 1'b0;
    @(negedge fpga_clk);

    // Reset held with random inputs, then released with enable low.
    t0 = cyc;
    for (int i = 1; i <= 4; i++) expect_at(i, M_ALL, 0, 0, 0, 0, 2'b00, 7'd0, "reset_hold");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom), 12'($urandom), 8'($urandom));
      @(negedge fpga_clk);
    end
    reset_n = 1'b1;
    applyStimulus(1'b0, 12'($urandom), 8'($urandom));
    t0 = cyc;
    for (int i = 1; i <= 3; i++) expect_at(i, M_ALL, 0, 0, 0, 0, 2'b00, 7'd0, "released_idle");
    wait_until(3);

    // Frequency, lock acquisition with error +1, then loss behaviour.
    applyStimulus(1'b1, 12'd256, 8'd1);
    t0 = cyc + 1;
    expect_at(0,    M_ALL,  0, 0, 0, 0, 2'b01, 7'd0, "enable_start");
    expect_at(7,    M_CLK,  0, 0, 0, 0, 2'b00, 7'd0, "clk_before_first_rise");
    expect_at(8,    M_CLK,  1, 0, 0, 0, 2'b00, 7'd0, "clk_first_rise");
    expect_at(15,   M_CLK,  1, 0, 0, 0, 2'b00, 7'd0, "clk_high_end");
    expect_at(16,   M_CLK,  0, 0, 0, 0, 2'b00, 7'd0, "clk_fall");
    expect_at(24,   M_CLK,  1, 0, 0, 0, 2'b00, 7'd0, "clk_second_rise");
    expect_at(55,   M_DIV,  0, 0, 0, 0, 2'b00, 7'd0, "div_before_rise");
    expect_at(56,   M_DIV,  0, 1, 0, 0, 2'b00, 7'd0, "div_rise");
    expect_at(119,  M_DIV,  0, 1, 0, 0, 2'b00, 7'd0, "div_high_end");
    expect_at(120,  M_DIV,  0, 0, 0, 0, 2'b00, 7'd0, "div_fall");
    expect_at(184,  M_DIV,  0, 1, 0, 0, 2'b00, 7'd0, "div_second_rise");
    expect_at(2040, M_LCK | M_ST, 0, 0, 0, 0, 2'b01, 7'd0, "pre_lock");
    expect_at(2041, M_LCK | M_ST | M_PK | M_LOST, 0, 0, 1, 0, 2'b10, 7'd0, "lock_entry");
    expect_at(2168, M_PK,   0, 0, 0, 0, 2'b00, 7'd0, "peak_before_sample");
    expect_at(2169, M_PK | M_LCK, 0, 0, 1, 0, 2'b00, 7'd1, "peak_after_sample");
    expect_at(2297, M_PK | M_LCK | M_ST, 0, 0, 1, 0, 2'b10, 7'd5, "peak_minus5");
    expect_at(2553, M_PK | M_LCK | M_ST, 0, 0, 1, 0, 2'b10, 7'd5, "three_bad_locked");
    expect_at(2681, M_PK | M_LCK | M_ST, 0, 0, 1, 0, 2'b10, 7'd5, "recovered_locked");
    expect_at(3192, M_LOST | M_ST | M_LCK, 0, 0, 1, 0, 2'b10, 7'd0, "pre_loss");
    expect_at(3193, M_LOST | M_ST | M_LCK, 0, 0, 0, 1, 2'b01, 7'd0, "loss_pulse");
    expect_at(3194, M_LOST | M_ST, 0, 0, 0, 0, 2'b01, 7'd0, "loss_pulse_end");
    expect_at(3301, M_CLK | M_DIV | M_LCK | M_LOST | M_ST, 0, 0, 0, 0, 2'b00, 7'd0, "disable_from_acquire");
    pulse_q.push_back(t0 + 3193);
    wait_until(2200); applyStimulus(1'b1, 12'd256, 8'hFB);
    wait_until(2600); applyStimulus(1'b1, 12'd256, 8'h00);
    wait_until(2700); applyStimulus(1'b1, 12'd256, 8'hFB);
    wait_until(3300); applyStimulus(1'b0, 12'd256, 8'h00);
    wait_until(3303);

    // Relock with one out-of-threshold sample, saturation, threshold boundary,
    // and a disable that coincides with a loss decision.
    applyStimulus(1'b1, 12'd256, 8'd1);
    t0 = cyc + 1;
    expect_at(2041, M_LCK | M_ST, 0, 0, 0, 0, 2'b01, 7'd0, "no_lock_after_reset_cnt");
    expect_at(3320, M_LCK | M_ST, 0, 0, 0, 0, 2'b01, 7'd0, "pre_delayed_lock");
    expect_at(3321, M_LCK | M_ST | M_PK | M_LOST, 0, 0, 1, 0, 2'b10, 7'd0, "delayed_lock_peak_clear");
    expect_at(3448, M_PK | M_LCK, 0, 0, 1, 0, 2'b00, 7'd0, "peak_before_sat");
    expect_at(3449, M_PK | M_LCK | M_ST, 0, 0, 1, 0, 2'b10, 7'd127, "peak_saturated");
    expect_at(3577, M_PK | M_LCK | M_ST, 0, 0, 1, 0, 2'b10, 7'd127, "thresh_boundary_in");
    expect_at(3961, M_LCK | M_ST, 0, 0, 1, 0, 2'b10, 7'd0, "three_bad_still_locked");
    expect_at(4088, M_CLK | M_LCK | M_ST, 1, 0, 1, 0, 2'b10, 7'd0, "before_disable");
    expect_at(4089, M_CLK | M_DIV | M_LCK | M_LOST | M_ST, 0, 0, 0, 0, 2'b00, 7'd0, "disable_wins_over_loss");
    expect_at(4090, M_LOST | M_ST, 0, 0, 0, 0, 2'b00, 7'd0, "no_pulse_after_disable");
    wait_until(1200); applyStimulus(1'b1, 12'd256, 8'd3);
    wait_until(1300); applyStimulus(1'b1, 12'd256, 8'd1);
    wait_until(3400); applyStimulus(1'b1, 12'd256, 8'h80);
    wait_until(3500); applyStimulus(1'b1, 12'd256, 8'hFE);
    wait_until(3600); applyStimulus(1'b1, 12'd256, 8'hFB);
    wait_until(4088); applyStimulus(1'b0, 12'd256, 8'hFB);
    wait_until(4093);

    // Asynchronous reset asserted between clock edges.
    applyStimulus(1'b1, 12'd256, 8'd0);
    t0 = cyc + 1;
    expect_at(12, M_CLK | M_ST, 1, 0, 0, 0, 2'b01, 7'd0, "running_before_reset");
    expect_at(13, M_ALL, 0, 0, 0, 0, 2'b00, 7'd0, "async_reset_mid_period");
    wait_until(12);
    @(posedge fpga_clk);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge fpga_clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 12'd256, 8'd0);
    repeat (2) @(negedge fpga_clk);

    // Frequency word change mid-period takes effect at the next div8 rise.
    applyStimulus(1'b1, 12'd256, 8'd0);
    t0 = cyc + 1;
    expect_at(103, M_CLK, 0, 0, 0, 0, 2'b00, 7'd0, "old_k_low");
    expect_at(104, M_CLK, 1, 0, 0, 0, 2'b00, 7'd0, "old_k_rise");
    expect_at(111, M_CLK, 1, 0, 0, 0, 2'b00, 7'd0, "old_k_high");
    expect_at(112, M_CLK, 0, 0, 0, 0, 2'b00, 7'd0, "old_k_fall");
    expect_at(184, M_CLK | M_DIV, 1, 1, 0, 0, 2'b00, 7'd0, "k_load_edge");
    expect_at(187, M_CLK, 1, 0, 0, 0, 2'b00, 7'd0, "new_k_high");
    expect_at(188, M_CLK, 0, 0, 0, 0, 2'b00, 7'd0, "new_k_fall");
    expect_at(191, M_CLK, 0, 0, 0, 0, 2'b00, 7'd0, "new_k_low");
    expect_at(192, M_CLK, 1, 0, 0, 0, 2'b00, 7'd0, "new_k_rise");
    expect_at(196, M_CLK, 0, 0, 0, 0, 2'b00, 7'd0, "new_k_fall2");
    expect_at(215, M_DIV, 0, 1, 0, 0, 2'b00, 7'd0, "new_k_div_high");
    expect_at(216, M_DIV, 0, 0, 0, 0, 2'b00, 7'd0, "new_k_div_fall");
    wait_until(70); applyStimulus(1'b1, 12'd512, 8'd0);
    wait_until(220);
    repeat (3) @(negedge fpga_clk);

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s never checked: due at cyc %0d", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end
    while (pulse_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL lock_lost_pulse never seen: expected at cyc %0d", pulse_q[0]);
      void'(pulse_q.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog expired at cyc %0d, want completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
